// File: rtl/contador_param.sv
// contador_param: parametrised up/down modulo counter with a registered terminal-count pulse and a sticky overflow flag.
// Build option: define CONTADOR_PARAM_SATURATE_EN to clamp at the range limits instead of wrapping.
module contador_param #(
    parameter int WIDTH   = 12,
    parameter int MAX_VAL = 4095,
    parameter int STEP    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic             up,
    input  logic [WIDTH-1:0] loadbits,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    // One extra bit keeps sum and wrap intermediates exact when MAX_VAL = 2^WIDTH-1.
    localparam logic [WIDTH:0]   MAX_X  = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0]   MOD_X  = (WIDTH+1)'(MAX_VAL + 1);
    localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] MAX_N  = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH:0]   cnt_x;
    logic [WIDTH:0]   sum_x;
    logic [WIDTH:0]   load_x;
    logic [WIDTH-1:0] step_n;
    logic             evt;

    always_comb begin
        cnt_x  = {1'b0, count_q};
        sum_x  = cnt_x + STEP_X;
        load_x = {1'b0, loadbits};
        evt    = 1'b0;
        step_n = count_q;

        if (up) begin
            if (sum_x > MAX_X) begin
                evt = 1'b1;
`ifdef CONTADOR_PARAM_SATURATE_EN
                step_n = MAX_N;
`else
                step_n = WIDTH'(sum_x - MOD_X);
`endif
            end else begin
                step_n = WIDTH'(sum_x);
            end
        end else begin
            if (cnt_x < STEP_X) begin
                evt = 1'b1;
`ifdef CONTADOR_PARAM_SATURATE_EN
                step_n = '0;
`else
                step_n = WIDTH'(cnt_x + MOD_X - STEP_X);
`endif
            end else begin
                step_n = WIDTH'(cnt_x - STEP_X);
            end
        end
    end

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        ovf_d   = ovf_q & ~clr_ovf;

        if (load) begin
            count_d = (load_x > MAX_X) ? MAX_N : loadbits;
        end else if (enable) begin
            count_d = step_n;
            tc_d    = evt;
            if (evt) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_contador_param.sv
// Directed bench for contador_param: default 12-bit/4095/step-1 instance and a 4-bit/mod-10/step-3 instance.
// Expectations follow CONTADOR_PARAM_SATURATE_EN when it is defined for the build.
module tb_contador_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        d_reset, d_enable, d_load, d_up, d_clr;
    logic [11:0] d_loadbits;
    logic [11:0] d_count;
    logic        d_tc, d_ovf;

    logic        m_reset, m_enable, m_load, m_up, m_clr;
    logic [3:0]  m_loadbits;
    logic [3:0]  m_count;
    logic        m_tc, m_ovf;

`ifdef CONTADOR_PARAM_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    contador_param u_def (
        .clk(clk), .reset(d_reset), .enable(d_enable), .load(d_load), .up(d_up),
        .loadbits(d_loadbits), .clr_ovf(d_clr),
        .count(d_count), .tc(d_tc), .ovf(d_ovf)
    );

    contador_param #(.WIDTH(4), .MAX_VAL(9), .STEP(3)) u_mod (
        .clk(clk), .reset(m_reset), .enable(m_enable), .load(m_load), .up(m_up),
        .loadbits(m_loadbits), .clr_ovf(m_clr),
        .count(m_count), .tc(m_tc), .ovf(m_ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_d(input string tag, input int c, input logic t, input logic o);
        chk({tag, ".count"}, 32'(d_count), c);
        chk({tag, ".tc"}, 32'(d_tc), 32'(t));
        chk({tag, ".ovf"}, 32'(d_ovf), 32'(o));
    endtask

    task automatic chk_m(input string tag, input int c, input logic t, input logic o);
        chk({tag, ".count"}, 32'(m_count), c);
        chk({tag, ".tc"}, 32'(m_tc), 32'(t));
        chk({tag, ".ovf"}, 32'(m_ovf), 32'(o));
    endtask

    initial begin
        d_reset = 1'b0; d_enable = 1'b1; d_load = 1'b1; d_up = 1'b1; d_clr = 1'b0; d_loadbits = 12'h123;
        m_reset = 1'b0; m_enable = 1'b1; m_load = 1'b0; m_up = 1'b1; m_clr = 1'b0; m_loadbits = 4'h0;

        // reset for two cycles with load/enable active: must be ignored
        tick(); tick();
        chk_d("d_reset", 0, 1'b0, 1'b0);
        chk_m("m_reset", 0, 1'b0, 1'b0);

        // first edge out of reset honours load
        d_reset = 1'b1; d_enable = 1'b0; d_load = 1'b1; d_loadbits = 12'h901;
        tick();
        chk_d("d_load901", 'h901, 1'b0, 1'b0);

        d_enable = 1'b1; d_loadbits = 12'h800;
        tick();
        chk_d("d_load_over_en", 'h800, 1'b0, 1'b0);

        // up across MAX_VAL
        d_enable = 1'b0; d_loadbits = 12'd4094;
        tick();
        chk_d("d_load4094", 4094, 1'b0, 1'b0);
        d_load = 1'b0; d_enable = 1'b1; d_up = 1'b1;
        tick(); chk_d("d_up1", 4095, 1'b0, 1'b0);
        tick(); chk_d("d_up2", SAT ? 4095 : 0, 1'b1, 1'b1);
        tick(); chk_d("d_up3", SAT ? 4095 : 1, SAT, 1'b1);

        d_enable = 1'b0; d_clr = 1'b1;
        tick(); chk_d("d_clr", SAT ? 4095 : 1, 1'b0, 1'b0);
        d_clr = 1'b0;

        // down across zero
        d_load = 1'b1; d_loadbits = 12'd1;
        tick(); chk_d("d_load1", 1, 1'b0, 1'b0);
        d_load = 1'b0; d_enable = 1'b1; d_up = 1'b0;
        tick(); chk_d("d_dn1", 0, 1'b0, 1'b0);
        tick(); chk_d("d_dn2", SAT ? 0 : 4095, 1'b1, 1'b1);

        // load honours clr_ovf and clears tc
        d_enable = 1'b0; d_load = 1'b1; d_loadbits = 12'd4095; d_clr = 1'b1;
        tick(); chk_d("d_load_clr", 4095, 1'b0, 1'b0);

        // boundary event and clr_ovf together: set wins
        d_load = 1'b0; d_enable = 1'b1; d_up = 1'b1; d_clr = 1'b1;
        tick(); chk_d("d_evt_clr", SAT ? 4095 : 0, 1'b1, 1'b1);

        // enable dropped: hold with tc low
        d_enable = 1'b0; d_clr = 1'b0;
        tick(); chk_d("d_hold", SAT ? 4095 : 0, 1'b0, 1'b1);
        tick(); chk_d("d_hold2", SAT ? 4095 : 0, 1'b0, 1'b1);

        // reset wins over load and enable
        d_reset = 1'b0; d_load = 1'b1; d_enable = 1'b1; d_loadbits = 12'd7;
        tick(); chk_d("d_rst_prio", 0, 1'b0, 1'b0);
        d_reset = 1'b1; d_load = 1'b0; d_enable = 1'b0;

        // modulo-10 step-3 instance
        m_reset = 1'b1; m_enable = 1'b0; m_load = 1'b1; m_loadbits = 4'd0;
        tick(); chk_m("m_load0", 0, 1'b0, 1'b0);
        m_load = 1'b0; m_enable = 1'b1; m_up = 1'b1;
        tick(); chk_m("m_up3", 3, 1'b0, 1'b0);
        tick(); chk_m("m_up6", 6, 1'b0, 1'b0);
        tick(); chk_m("m_up9", 9, 1'b0, 1'b0);
        tick(); chk_m("m_upwrap", SAT ? 9 : 2, 1'b1, 1'b1);

        m_enable = 1'b0; m_load = 1'b1; m_loadbits = 4'd2; m_clr = 1'b1;
        tick(); chk_m("m_load2", 2, 1'b0, 1'b0);
        m_load = 1'b0; m_clr = 1'b0; m_enable = 1'b1; m_up = 1'b0;
        tick(); chk_m("m_dnwrap", SAT ? 0 : 9, 1'b1, 1'b1);
        tick(); chk_m("m_dn2", SAT ? 0 : 6, SAT, 1'b1);

        // direction change between cycles
        m_enable = 1'b0; m_load = 1'b1; m_loadbits = 4'd6; m_clr = 1'b1;
        tick(); chk_m("m_load6", 6, 1'b0, 1'b0);
        m_load = 1'b0; m_clr = 1'b0; m_enable = 1'b1; m_up = 1'b1;
        tick(); chk_m("m_dir_up", 9, 1'b0, 1'b0);
        m_up = 1'b0;
        tick(); chk_m("m_dir_dn", 6, 1'b0, 1'b0);
        m_up = 1'b1;
        tick(); chk_m("m_dir_up2", 9, 1'b0, 1'b0);

        // load clamping
        m_enable = 1'b0; m_load = 1'b1; m_loadbits = 4'hF;
        tick(); chk_m("m_clampF", 9, 1'b0, 1'b0);
        m_loadbits = 4'd10;
        tick(); chk_m("m_clampA", 9, 1'b0, 1'b0);
        m_loadbits = 4'd8;
        tick(); chk_m("m_load8", 8, 1'b0, 1'b0);
        m_load = 1'b0; m_enable = 1'b1; m_up = 1'b1;
        tick(); chk_m("m_up8", SAT ? 9 : 1, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/contador_param.md
# contador_param

Parametrised successor to the team's 12-bit loadable counter. Adds configurable width, modulus and step, an up/down direction input, a one-cycle terminal-count pulse and a sticky overflow flag with clear. Used as the general-purpose counter/timer primitive in the lab designs, typically driven by switches or an FSM enable.

## Interface
Parameters:
- `WIDTH`, 12: counter width in bits.
- `MAX_VAL`, 4095: highest count value. The count range is 0..MAX_VAL. Legal range is 1..2^WIDTH-1.
- `STEP`, 1: increment/decrement per enabled cycle. Legal range is 1..MAX_VAL.

Ports:
- `clk` input 1: clock. All state updates on the rising edge.
- `reset` input 1: synchronous, active-low reset.
- `enable` input 1: count one step this cycle.
- `load` input 1: load `loadbits` this cycle.
- `up` input 1: direction. 1 = count up, 0 = count down.
- `loadbits` input WIDTH: parallel load value.
- `clr_ovf` input 1: clear the sticky overflow flag.
- `count` output WIDTH: current count.
- `tc` output 1: terminal-count pulse, registered.
- `ovf` output 1: sticky boundary-event flag.

## Operation
- Priority at each rising edge: `reset`=0, then `load`, then `enable`, then hold.
- Reset (`reset`=0):
  - `count`=0, `tc`=0, `ovf`=0.
  - All other inputs are ignored.
  - Reset asserted mid-count takes effect at the next edge, with no partial update.
- Load:
  - `count` <= `loadbits` if `loadbits` <= MAX_VAL, else `count` <= MAX_VAL (clamp).
  - `tc` <= 0. `ovf` is unchanged, but `clr_ovf` is still honoured.
  - `enable` is ignored in the same cycle.
- Enable with `up`=1:
  - Compute sum = `count` + STEP in WIDTH+1 bits.
  - If sum <= MAX_VAL: `count` <= sum, with no event.
  - Otherwise it is a boundary event: `count` <= sum - (MAX_VAL+1) (wrap).
- Enable with `up`=0:
  - If `count` >= STEP: `count` <= `count` - STEP, with no event.
  - Otherwise it is a boundary event: `count` <= `count` + (MAX_VAL+1) - STEP (wrap).
- All arithmetic uses WIDTH+1 bits internally. No intermediate value may truncate.
- `tc`:
  - Registered. It is 1 for exactly the cycle following an enabled step that produced a boundary event, otherwise 0.
  - Consecutive boundary events give consecutive `tc` cycles.
- `ovf`:
  - Set on any boundary event.
  - Cleared when `clr_ovf`=1.
  - If a boundary event and `clr_ovf` occur in the same cycle, set wins.
- Changing `up` between cycles is legal. Each cycle uses the `up` value sampled at that edge.

## Timing
- Single clock domain. All outputs are registered, with no combinational input-to-output path.
- Latency: an input sampled at edge N is visible on `count`/`tc`/`ovf` after edge N.
- Reset values: `count`=0, `tc`=0, `ovf`=0.
- `enable` is level-sensitive: one step per rising edge while high.
- The first edge with `reset`=1 after reset still honours `load`/`enable`. There is no dead cycle.

## Configuration
- Macro: `CONTADOR_PARAM_SATURATE_EN`.
- Defined (saturation mode), on a boundary event:
  - `count` clamps to MAX_VAL when counting up, or to 0 when counting down.
  - `tc` and `ovf` behave as above, so holding at the limit with `enable`=1 gives `tc`=1 every cycle.
- Undefined (default): wrap-around as specified in Operation.
- Load clamping and all other behaviour are identical in both modes.

## Test plan
- Reset and load, defaults (WIDTH=12, MAX_VAL=4095):
  - `reset`=0 for 2 cycles gives `count`=0, `tc`=0, `ovf`=0.
  - Then `load`=1 with `loadbits`=12'h901 gives `count`=12'h901.
  - Then `load`=1 and `enable`=1 with `loadbits`=12'h800 gives `count`=12'h800, not 12'h801.
- Up wrap (MAX_VAL=4095, STEP=1):
  - Load 4094, then enable for 3 cycles: `count` goes 4095, 0, 1.
  - `tc`=1 only in the cycle `count`=0. `ovf`=1 thereafter.
  - `clr_ovf`=1 for 1 cycle gives `ovf`=0.
- Modulo and step (WIDTH=4, MAX_VAL=9, STEP=3):
  - Up from 0: 3, 6, 9, 2 (`tc` with 2).
  - Down from 2: 9 (`tc`), 6.
  - Load 4'hF clamps to 9.
- Simultaneous events:
  - Boundary event coinciding with `clr_ovf`=1 leaves `ovf`=1.
  - `reset`=0 together with `load`=1 and `enable`=1 gives `count`=0.
  - Enable dropped mid-run holds `count` with `tc`=0.
- Saturation (`CONTADOR_PARAM_SATURATE_EN`, MAX_VAL=4095):
  - Load 4094, then enable up for 3 cycles: 4095, 4095, 4095, with `tc`=1 on the 2nd and 3rd.
  - Load 1, then enable down for 2 cycles: 0, 0, with `tc` on the 2nd.
